if_stage_param: RTL and testbench

- Parametrised instruction-fetch stage for the 5-stage ARM pipeline.
- Holds the PC and a word-addressed instruction ROM, selects between PC+4 and a branch target, and honours hazard freeze.
- Drives the IF/ID pipeline register, with flush on taken branch and a valid bit.
- Sits between the hazard unit/EXE branch logic and the ID stage.

---
 rtl/arm_pkg.sv | 11 +
 rtl/inst_mem.sv | 42 ++++
 rtl/if_stage_param.sv | 85 ++++++++
 tb/tb_if_stage_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared constants for the ARM pipeline front end.
//   ARM_NOP    : canonical no-op (MOV r0, r0) used for bubbles and unmapped fetches.
//   PC_INCR    : byte increment between sequential instructions.
//   WORD_SHIFT : byte-to-word address shift (instructions are 4-byte aligned).
package arm_pkg;

    localparam logic [31:0] ARM_NOP    = 32'hE1A0_0000;
    localparam int unsigned PC_INCR    = 4;
    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/inst_mem.sv
// Asynchronous, word-addressed instruction ROM.
// Ports:
//   word_addr (in,  N-2) : instruction word index (byte PC >> 2).
//   data      (out, N)   : instruction at word_addr, or NOP_INSTR when the index is
//                          beyond MEM_DEPTH.
module inst_mem
    import arm_pkg::*;
#(
    parameter int unsigned    N         = 32,
    parameter int unsigned    MEM_DEPTH = 64,
    parameter logic [N-1:0]   NOP_INSTR = N'(ARM_NOP)
) (
    input  logic [N-WORD_SHIFT-1:0] word_addr,
    output logic [N-1:0]            data
);

    // Program image. The first words form a short straight-line sequence; the remainder
    // is filled with "ADD r1, r1, #idx" so every location holds a distinct word.
    function automatic logic [31:0] program_word(input logic [63:0] idx);
        case (idx)
            64'd0:   program_word = 32'hE3A0_0001;  // mov r0, #1
            64'd1:   program_word = 32'hE3A0_1002;  // mov r1, #2
            64'd2:   program_word = 32'hE080_2001;  // add r2, r0, r1
            64'd3:   program_word = 32'hE042_3000;  // sub r3, r2, r0
            64'd4:   program_word = 32'hE580_3000;  // str r3, [r0]
            default: program_word = 32'hE281_1000 | {24'd0, idx[7:0]};
        endcase
    endfunction

    logic [63:0] idx_ext;

    always_comb begin
        // Widen before comparing so MEM_DEPTH never truncates against the index width.
        idx_ext = 64'(word_addr);
        if (idx_ext >= 64'(MEM_DEPTH)) begin
            data = NOP_INSTR;
        end else begin
            data = N'(program_word(idx_ext));
        end
    end

endmodule

// File: rtl/if_stage_param.sv
// Instruction-fetch stage: PC register, next-PC select, instruction ROM and IF/ID register.
// Ports:
//   clk           (in)     : rising-edge clock.
//   rst           (in)     : synchronous active-high reset, overrides all other inputs.
//   freeze        (in)     : hazard stall; PC and IF/ID hold.
//   branch_taken  (in)     : redirect fetch to branch_addr and flush IF/ID.
//   branch_addr   (in,  N) : branch target byte address (low two bits ignored).
//   pc_f          (out, N) : PC+4 of the instruction being fetched (combinational).
//   instruction_f (out, N) : ROM word at the current PC (combinational).
//   pc_d          (out, N) : registered PC+4 presented to ID.
//   instruction_d (out, N) : registered instruction presented to ID.
//   valid_d       (out)    : IF/ID holds a real fetched instruction.
module if_stage_param
    import arm_pkg::*;
#(
    parameter int unsigned  N         = 32,
    parameter int unsigned  MEM_DEPTH = 64,
    parameter logic [N-1:0] NOP_INSTR = N'(ARM_NOP),
    parameter logic [N-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_addr,
    output logic [N-1:0] pc_f,
    output logic [N-1:0] instruction_f,
    output logic [N-1:0] pc_d,
    output logic [N-1:0] instruction_d,
    output logic         valid_d
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_next;
    logic [N-1:0] branch_target;

    // Target is forced word aligned; its low bits are deliberately dropped.
    assign branch_target = {branch_addr[N-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};

    logic unused_branch_lsbs;
    assign unused_branch_lsbs = ^branch_addr[WORD_SHIFT-1:0];

    // Wraps modulo 2^N, so the last word of the address space is followed by address 0.
    assign pc_f = pc_q + N'(PC_INCR);

    always_comb begin
        pc_next = pc_f;
        if (branch_taken) begin
            pc_next = branch_target;
        end else if (freeze) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    inst_mem #(
        .N         (N),
        .MEM_DEPTH (MEM_DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_inst_mem (
        .word_addr (pc_q[N-1:WORD_SHIFT]),
        .data      (instruction_f)
    );

    // IF/ID register: a taken branch squashes the wrong-path fetch even when stalled.
    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            pc_d          <= '0;
            instruction_d <= NOP_INSTR;
            valid_d       <= 1'b0;
        end else if (!freeze) begin
            pc_d          <= pc_f;
            instruction_d <= instruction_f;
            valid_d       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage_param.sv
module tb_if_stage_param;

    localparam logic [31:0] NOP   = 32'hE1A0_0000;
    localparam logic [31:0] ROM0  = 32'hE3A0_0001;
    localparam logic [31:0] ROM1  = 32'hE3A0_1002;
    localparam logic [31:0] ROM2  = 32'hE080_2001;
    localparam logic [31:0] ROM3  = 32'hE042_3000;
    localparam logic [31:0] ROM8  = 32'hE281_1008;
    localparam logic [31:0] ROM16 = 32'hE281_1010;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] pc_f;
    logic [31:0] instruction_f;
    logic [31:0] pc_d;
    logic [31:0] instruction_d;
    logic        valid_d;

    int checks;
    int failures;

    if_stage_param #(
        .N         (32),
        .MEM_DEPTH (64),
        .NOP_INSTR (32'hE1A0_0000),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .pc_f          (pc_f),
        .instruction_f (instruction_f),
        .pc_d          (pc_d),
        .instruction_d (instruction_d),
        .valid_d       (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr, input logic exp_valid);
        check({tag, ".pc_d"}, pc_d, exp_pc);
        check({tag, ".instr_d"}, instruction_d, exp_instr);
        check({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, exp_valid});
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;

        // Reset held for two edges.
        step();
        step();
        check_id("reset", 32'h0, NOP, 1'b0);
        check("reset.pc_f", pc_f, 32'h4);
        check("reset.instr_f", instruction_f, ROM0);

        // Straight-line run A,B,C,D.
        rst = 1'b0;
        step(); check_id("run0", 32'h4,  ROM0, 1'b1);
        step(); check_id("run1", 32'h8,  ROM1, 1'b1);
        step(); check_id("run2", 32'hC,  ROM2, 1'b1);
        step(); check_id("run3", 32'h10, ROM3, 1'b1);

        // Short reset mid-run, then refetch up to PC = 8.
        rst = 1'b1;
        step(); check_id("rst_mid", 32'h0, NOP, 1'b0);
        check("rst_mid.pc_f", pc_f, 32'h4);
        rst = 1'b0;
        step(); check_id("rerun0", 32'h4, ROM0, 1'b1);
        step(); check_id("rerun1", 32'h8, ROM1, 1'b1);
        check("pc8.pc_f", pc_f, 32'hC);

        // Freeze three cycles at PC = 8.
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz.pc_f", pc_f, 32'hC);
            check_id("frz", 32'h8, ROM1, 1'b1);
        end
        freeze = 1'b0;
        step(); check_id("unfrz", 32'hC, ROM2, 1'b1);
        check("unfrz.pc_f", pc_f, 32'h10);

        // Branch at PC = 12 to 0x23 (aligned to 0x20).
        branch_taken = 1'b1;
        branch_addr  = 32'h23;
        step();
        check("br.pc_f", pc_f, 32'h24);
        check("br.instr_f", instruction_f, ROM8);
        check_id("br_flush", 32'h0, NOP, 1'b0);
        branch_taken = 1'b0;
        step(); check_id("br_tgt", 32'h24, ROM8, 1'b1);

        // Branch and freeze together: branch wins.
        branch_taken = 1'b1;
        freeze       = 1'b1;
        branch_addr  = 32'h40;
        step();
        check("brfrz.pc_f", pc_f, 32'h44);
        check("brfrz.instr_f", instruction_f, ROM16);
        check_id("brfrz", 32'h0, NOP, 1'b0);

        // Branch past the end of ROM.
        freeze      = 1'b0;
        branch_addr = 32'h100;
        step();
        check("oor.pc_f", pc_f, 32'h104);
        check("oor.instr_f", instruction_f, NOP);
        branch_taken = 1'b0;
        step(); check_id("oor_load", 32'h104, NOP, 1'b1);

        // Branch to top of address space; PC+4 wraps to zero.
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        check("wrap.pc_f", pc_f, 32'h0);
        check("wrap.instr_f", instruction_f, NOP);
        branch_taken = 1'b0;
        step();
        check_id("wrap_load", 32'h0, NOP, 1'b1);
        check("wrap0.instr_f", instruction_f, ROM0);
        check("wrap0.pc_f", pc_f, 32'h4);

        // Reset during a freeze, with a branch also requested.
        freeze = 1'b1;
        step();
        check("frz0.pc_f", pc_f, 32'h4);
        check_id("frz0", 32'h0, NOP, 1'b1);
        rst          = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        step();
        check("rstfrz.pc_f", pc_f, 32'h4);
        check_id("rstfrz", 32'h0, NOP, 1'b0);
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        step(); check_id("post_rst", 32'h4, ROM0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
